stream_arbiter: RTL

Per-slave-port packet arbiter that sits directly downstream of the request generator in the stream crossbar. It takes the per-master request vector for one slave port and grants exactly one master at a time, round-robin. The grant is held for a whole packet, until the beat carrying tlast is accepted on that slave port. One instance exists per slave port; its one-hot grant drives the crossbar data/valid mux and ready demux for that port.

---
 rtl/stream_arbiter.sv | 72 +++++++
 1 files changed

// File: rtl/stream_arbiter.sv
// Per-slave-port round-robin packet arbiter: grants one master at a time and
// holds the grant until the tlast beat is accepted, then re-arbitrates at once.
module stream_arbiter #(
   parameter  int S_DATA_COUNT    = 2,
   localparam int GRANT_IDX_WIDTH = $clog2(S_DATA_COUNT)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [S_DATA_COUNT-1:0]    req_i,
   input  logic                       beat_done_i,
   input  logic                       last_i,
   output logic [S_DATA_COUNT-1:0]    grant_o,
   output logic [GRANT_IDX_WIDTH-1:0] grant_idx_o,
   output logic                       busy_o
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

   logic [0:0]                 state_q;
   logic [GRANT_IDX_WIDTH-1:0] ptr_q;
   logic [GRANT_IDX_WIDTH-1:0] win;
   logic [GRANT_IDX_WIDTH-1:0] ptr_nxt;
   logic [S_DATA_COUNT-1:0]    win_oh;
   logic                       found;
   logic                       arb_en;

   // First requester at or after ptr, wrapping modulo S_DATA_COUNT.
   always_comb begin
      found = 1'b0;
      win   = ptr_q;
      for (int o = 0; o < S_DATA_COUNT; o++) begin
         int idx;
         idx = (int'(ptr_q) + o) % S_DATA_COUNT;
         if (!found && req_i[idx]) begin
            found = 1'b1;
            win   = GRANT_IDX_WIDTH'(idx);
         end
      end
   end

   always_comb begin
      win_oh      = '0;
      win_oh[win] = 1'b1;
      ptr_nxt     = (int'(win) == S_DATA_COUNT - 1) ? '0 : win + GRANT_IDX_WIDTH'(1);
   end

   // Locked grants only move on the accepted tlast beat; that edge re-arbitrates.
   assign arb_en = (state_q == IDLE) || (beat_done_i && last_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_o     <= '0;
         grant_idx_o <= '0;
         ptr_q       <= '0;
      end else if (arb_en) begin
         if (found) begin
            state_q     <= LOCKED;
            grant_o     <= win_oh;
            grant_idx_o <= win;
            ptr_q       <= ptr_nxt;
         end else begin
            state_q <= IDLE;
            grant_o <= '0;
         end
      end
   end

   assign busy_o = (state_q == LOCKED);

endmodule
